// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit and the hazard unit.
package md_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP6  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_e;

    // True for ops that occupy the unit for multiple cycles (mult/div).
    function automatic logic is_md_busy_op(input logic [OP_W-1:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational mult/div datapath: full {hi, lo} result for one op.
module md_compute
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] sa, sb, sq, sr;
    logic        [2*WIDTH-1:0] ua, ub, uq, ur;
    logic        [2*WIDTH-1:0] res;

    assign sa = {{WIDTH{a[WIDTH-1]}}, a};
    assign sb = {{WIDTH{b[WIDTH-1]}}, b};
    assign ua = {{WIDTH{1'b0}}, a};
    assign ub = {{WIDTH{1'b0}}, b};

    // Select the result; divisions are only evaluated with a nonzero divisor.
    always_comb begin
        res = '0;
        sq  = '0;
        sr  = '0;
        uq  = '0;
        ur  = '0;
        case (md_op_e'(op))
            MD_MULT:  res = sa * sb;
            MD_MULTU: res = ua * ub;
            MD_DIV: begin
                if (b == '0) begin
                    res = {a, {WIDTH{1'b1}}};
                end else if (a == MIN_INT && b == {WIDTH{1'b1}}) begin
                    res = {{WIDTH{1'b0}}, MIN_INT};
                end else begin
                    // SV signed divide truncates toward zero; remainder follows dividend
                    sq  = sa / sb;
                    sr  = sa % sb;
                    res = {sr[WIDTH-1:0], sq[WIDTH-1:0]};
                end
            end
            MD_DIVU: begin
                if (b == '0) begin
                    res = {a, {WIDTH{1'b1}}};
                end else begin
                    uq  = ua / ub;
                    ur  = ua % ub;
                    res = {ur[WIDTH-1:0], uq[WIDTH-1:0]};
                end
            end
            default: res = '0;
        endcase
    end

    assign hi_n = res[2*WIDTH-1:WIDTH];
    assign lo_n = res[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at accept and held pending; HI/LO are written
// when the fixed-latency counter expires, unless cancelled first.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_n, lo_n;

    md_compute #(.WIDTH(WIDTH)) u_compute (
        .op   (op),
        .a    (a),
        .b    (b),
        .hi_n (hi_n),
        .lo_n (lo_n)
    );

    assign busy = (cnt_q != '0);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Next state: cancel first, then countdown/retire, then accept of a new op.
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (cancel) begin
            cnt_d  = '0;
            pend_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                {hi_d, lo_d} = pend_q;
                done_d       = 1'b1;
            end
        end else if (start) begin
            if (is_md_busy_op(op)) begin
                pend_d = {hi_n, lo_n};
                cnt_d  = (op == MD_MULT || op == MD_MULTU) ? CNT_W'(MULT_CYCLES)
                                                           : CNT_W'(DIV_CYCLES);
            end else if (op == MD_MTHI) begin
                hi_d = a;
            end else if (op == MD_MTLO) begin
                lo_d = a;
            end
        end
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            pend_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus corner-case sequences.
module tb_mult_div_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         cancel;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int npass = 0;
    int ntot  = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        int           n;
        string        name;
    } vec_t;

    vec_t vec[12];

    mult_div_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .cancel  (cancel),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Called at a negedge; issues the op and follows it to completion.
    task automatic run_op(input vec_t v);
        logic [W-1:0] oh, ol;
        logic ok;
        oh = hi; ol = lo; ok = 1'b1;
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        @(negedge clk);
        start = 1'b0;
        if (v.n == 0) begin
            chk({v.name, " busy"}, 64'(busy), 64'(0));
            chk({v.name, " done"}, 64'(done), 64'(0));
        end else begin
            for (int i = 0; i < v.n; i++) begin
                if (busy !== 1'b1 || done !== 1'b0 || hi !== oh || lo !== ol) ok = 1'b0;
                @(negedge clk);
            end
            chk({v.name, " busy window"}, 64'(ok), 64'(1));
            chk({v.name, " busy end"}, 64'(busy), 64'(0));
            chk({v.name, " done"}, 64'(done), 64'(1));
        end
        chk({v.name, " hi"}, 64'(hi), 64'(v.eh));
        chk({v.name, " lo"}, 64'(lo), 64'(v.el));
    endtask

    initial begin
        logic ok;
        vec_t v;
        vec[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC, "mult -2*3"};
        vec[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MC, "multu"};
        vec[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC, "div -7/2"};
        vec[3]  = '{3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        DC, "divu 7/2"};
        vec[4]  = '{3'd2, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, DC, "div by 0"};
        vec[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC, "div ovf"};
        vec[6]  = '{3'd3, 32'd9,        32'd0,        32'd9,        32'hFFFFFFFF, DC, "divu by 0"};
        vec[7]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        MC, "mult min*min"};
        vec[8]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC, "multu max"};
        vec[9]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DC, "div 7/-2"};
        vec[10] = '{3'd4, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFD, 0,  "mthi"};
        vec[11] = '{3'd5, 32'h5678,     32'd0,        32'h1234,     32'h5678,     0,  "mtlo"};

        reset_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; cancel = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset hi", 64'(hi), 64'(0));
        chk("reset lo", 64'(lo), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));

        // All vectors are issued back-to-back, each in the previous done cycle.
        for (int i = 0; i < 12; i++) run_op(vec[i]);

        // start while busy is ignored
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        op = 3'd4; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < DC - 1; i++) @(negedge clk);
        chk("ignored start done", 64'(done), 64'(1));
        chk("ignored start hi", 64'(hi), 64'(2));
        chk("ignored start lo", 64'(lo), 64'(14));

        // cancel in cycle 4 of a divide
        start = 1'b1; op = 3'd2; a = 32'd50; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", 64'(busy), 64'(0));
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) ok = 1'b0;
            @(negedge clk);
        end
        chk("cancel no write", 64'(ok), 64'(1));

        // cancel dominates a simultaneous start
        start = 1'b1; op = 3'd4; a = 32'hBEEF; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("cancel+start hi", 64'(hi), 64'(2));
        chk("cancel+start busy", 64'(busy), 64'(0));

        // cancel on the final-count edge
        start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < DC - 1; i++) @(negedge clk);
        chk("last cycle busy", 64'(busy), 64'(1));
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("late cancel busy", 64'(busy), 64'(0));
        chk("late cancel done", 64'(done), 64'(0));
        chk("late cancel hi", 64'(hi), 64'(2));
        chk("late cancel lo", 64'(lo), 64'(14));

        // op 6 is a no-op
        start = 1'b1; op = 3'd6; a = 32'hAAAA;
        @(negedge clk);
        start = 1'b0;
        chk("nop busy", 64'(busy), 64'(0));
        chk("nop hi/lo", {32'(hi), 32'(lo)}, {32'd2, 32'd14});

        // explicit back-to-back pair
        v = '{3'd0, 32'd6, 32'd7, 32'd0, 32'd42, MC, "b2b mult"};
        run_op(v);
        v = '{3'd3, 32'd100, 32'd9, 32'd1, 32'd11, DC, "b2b divu"};
        run_op(v);

        // asynchronous reset mid-multiply
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst hi", 64'(hi), 64'(0));
        chk("async rst lo", 64'(lo), 64'(0));
        chk("async rst busy", 64'(busy), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < MC + 2; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) ok = 1'b0;
        end
        chk("post rst idle", 64'(ok), 64'(1));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
